// File: rtl/struct_s_pkg.sv
// Shared Ethernet framing constants for the user-data strip path.
// Holds the local MAC addresses, the user ethertype and the header/payload split of a 512-bit flit.
package struct_s;

  localparam int DATA_W = 512;
  localparam int HDR_W  = 112;
  localparam int PAY_W  = DATA_W - HDR_W;
  localparam int EMPTY_W = 6;

  localparam logic [47:0] DST_MAC = 48'h02_00_00_00_00_02;
  localparam logic [47:0] SRC_MAC = 48'h02_00_00_00_00_01;
  localparam logic [15:0] ETH_USR = 16'h88B5;

  // Byte counts used for the empty-field arithmetic
  localparam logic [EMPTY_W-1:0] HDR_BYTES       = 6'd14;
  localparam logic [EMPTY_W-1:0] FIRST_PAY_BYTES = 6'd50;

endpackage

// File: rtl/usr_strip.sv
// Strips the 14-byte Ethernet header and realigns the payload to the top of each 512-bit output flit.
// Optional USR_STRIP_ETYPE_CHECK_EN drops frames not addressed to SRC_MAC or not carrying ETH_USR.
module usr_strip
  import struct_s::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [DATA_W-1:0]  in_data,
  input  logic               in_valid,
  input  logic               in_sop,
  input  logic               in_eop,
  input  logic [EMPTY_W-1:0] in_empty,
  output logic               in_ready,
  output logic [DATA_W-1:0]  out_usr_data,
  output logic               out_usr_valid,
  output logic               out_usr_sop,
  output logic               out_usr_eop,
  output logic [EMPTY_W-1:0] out_usr_empty,
  input  logic               out_usr_ready,
  output logic [31:0]        drop_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BODY = 2'd1,
    TAIL = 2'd2,
    DROP = 2'd3
  } state_t;

  state_t             state_q;
  logic [PAY_W-1:0]   held_q;
  logic               first_q;
  logic [EMPTY_W-1:0] tail_empty_q;
  logic [DATA_W-1:0]  out_data_q;
  logic               out_valid_q;
  logic               out_sop_q;
  logic               out_eop_q;
  logic [EMPTY_W-1:0] out_empty_q;
  logic [31:0]        drop_cnt_q;

  logic out_free;
  logic accept;
  logic short_sop;
  logic hdr_bad;
  logic drop_sop;

  assign out_free  = !out_valid_q || out_usr_ready;
  // DROP never produces output, so it may swallow flits even while the output is stalled
  assign in_ready  = rst && ((state_q == DROP) || (out_free && (state_q != TAIL)));
  assign accept    = in_valid && in_ready;
  assign short_sop = in_empty > FIRST_PAY_BYTES;

`ifdef USR_STRIP_ETYPE_CHECK_EN
  assign hdr_bad = (in_data[DATA_W-1 -: 48] != SRC_MAC) ||
                   (in_data[PAY_W +: 16] != ETH_USR);
`else
  assign hdr_bad = 1'b0;
`endif

  assign drop_sop = short_sop || hdr_bad;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      held_q       <= '0;
      first_q      <= 1'b0;
      tail_empty_q <= '0;
      out_valid_q  <= 1'b0;
      out_sop_q    <= 1'b0;
      out_eop_q    <= 1'b0;
      out_empty_q  <= '0;
      drop_cnt_q   <= '0;
    end else begin
      if (out_valid_q && out_usr_ready) begin
        out_valid_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (accept && in_sop) begin
            if (drop_sop) begin
              drop_cnt_q <= drop_cnt_q + 32'd1;
              if (!in_eop) begin
                state_q <= DROP;
              end
            end else if (in_eop) begin
              // A header-only frame (empty = 50) wraps the 6-bit empty field to 0
              out_valid_q <= 1'b1;
              out_data_q  <= {in_data[PAY_W-1:0], {HDR_W{1'b0}}};
              out_sop_q   <= 1'b1;
              out_eop_q   <= 1'b1;
              out_empty_q <= in_empty + HDR_BYTES;
            end else begin
              held_q  <= in_data[PAY_W-1:0];
              first_q <= 1'b1;
              state_q <= BODY;
            end
          end
        end

        BODY: begin
          if (accept) begin
            out_valid_q <= 1'b1;
            out_data_q  <= {held_q, in_data[DATA_W-1 -: HDR_W]};
            out_sop_q   <= first_q;
            out_eop_q   <= 1'b0;
            out_empty_q <= '0;
            first_q     <= 1'b0;
            held_q      <= in_data[PAY_W-1:0];
            if (in_eop) begin
              if (in_empty >= FIRST_PAY_BYTES) begin
                out_eop_q   <= 1'b1;
                out_empty_q <= in_empty - FIRST_PAY_BYTES;
                state_q     <= IDLE;
              end else begin
                // Leftover bytes of the last flit go out on their own in TAIL
                tail_empty_q <= in_empty + HDR_BYTES;
                state_q      <= TAIL;
              end
            end
          end
        end

        TAIL: begin
          if (out_free) begin
            out_valid_q <= 1'b1;
            out_data_q  <= {held_q, {HDR_W{1'b0}}};
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b1;
            out_empty_q <= tail_empty_q;
            state_q     <= IDLE;
          end
        end

        DROP: begin
          if (accept && in_eop) begin
            state_q <= IDLE;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_usr_data  = out_data_q;
  assign out_usr_valid = out_valid_q;
  assign out_usr_sop   = out_sop_q;
  assign out_usr_eop   = out_eop_q;
  assign out_usr_empty = out_empty_q;
  assign drop_cnt      = drop_cnt_q;

endmodule

// File: tb/tb_usr_strip.sv
// Directed bench for usr_strip: frames are built as byte streams and expected output is the payload bytes repacked.
// Honours USR_STRIP_ETYPE_CHECK_EN for the ethertype filtering case.
`timescale 1ns/1ps
module tb_usr_strip;
  import struct_s::*;

  logic         clk = 1'b0;
  logic         rst;
  logic [511:0] in_data;
  logic         in_valid;
  logic         in_sop;
  logic         in_eop;
  logic [5:0]   in_empty;
  logic         in_ready;
  logic [511:0] out_usr_data;
  logic         out_usr_valid;
  logic         out_usr_sop;
  logic         out_usr_eop;
  logic [5:0]   out_usr_empty;
  logic         out_usr_ready;
  logic [31:0]  drop_cnt;

  always #5 clk = ~clk;

  usr_strip dut (
    .clk           (clk),
    .rst           (rst),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_sop        (in_sop),
    .in_eop        (in_eop),
    .in_empty      (in_empty),
    .in_ready      (in_ready),
    .out_usr_data  (out_usr_data),
    .out_usr_valid (out_usr_valid),
    .out_usr_sop   (out_usr_sop),
    .out_usr_eop   (out_usr_eop),
    .out_usr_empty (out_usr_empty),
    .out_usr_ready (out_usr_ready),
    .drop_cnt      (drop_cnt)
  );

  typedef struct {
    logic [511:0] data;
    logic         sop;
    logic         eop;
    logic [5:0]   empty;
  } flit_t;

  flit_t       got_q[$];
  flit_t       exp_q[$];
  logic [7:0]  frame[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic        toggle_en = 1'b0;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output monitor: one line per transferred flit
  always @(negedge clk) begin
    if (rst && out_usr_valid && out_usr_ready) begin
      got_q.push_back('{out_usr_data, out_usr_sop, out_usr_eop, out_usr_empty});
      $display("[%0t] out flit sop=%0b eop=%0b empty=%0d", $time, out_usr_sop, out_usr_eop, out_usr_empty);
    end
  end

  always @(posedge clk) begin
    #1;
    if (toggle_en) out_usr_ready = ~out_usr_ready;
  end

  task automatic build_frame(input int len, input logic [47:0] dst, input logic [15:0] etype, input logic [7:0] seed);
    logic [47:0] src;
    src = 48'h0A_0B_0C_0D_0E_0F;
    frame.delete();
    for (int i = 0; i < 6; i++) frame.push_back(dst[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) frame.push_back(src[47-8*i -: 8]);
    frame.push_back(etype[15:8]);
    frame.push_back(etype[7:0]);
    for (int i = 14; i < len; i++) frame.push_back(8'(seed + 8'(i * 7)));
  endtask

  task automatic send_flit(input logic [511:0] d, input logic s, input logic e, input logic [5:0] em);
    int t;
    t = 0;
    in_data = d; in_sop = s; in_eop = e; in_empty = em; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) chk("in_ready_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_empty = '0;
  endtask

  function automatic logic [511:0] pack_word(input int base, input int limit);
    logic [511:0] d;
    d = '0;
    for (int i = 0; i < 64; i++)
      if (base + i < limit) d[511-8*i -: 8] = frame[base + i];
    return d;
  endfunction

  task automatic send_frame(input int n_flits_max, input logic tail_check);
    int n, nf;
    n  = frame.size();
    nf = (n + 63) / 64;
    if (nf > n_flits_max) nf = n_flits_max;
    for (int f = 0; f < nf; f++) begin
      logic last;
      last = (f == (n + 63) / 64 - 1);
      send_flit(pack_word(f * 64, n), f == 0, last, last ? 6'((n + 63) / 64 * 64 - n) : 6'd0);
    end
    if (tail_check) begin
      @(negedge clk);
      chk("in_ready_in_tail", in_ready, 0);
      @(posedge clk); #1;
    end
  endtask

  // Expected output: payload bytes (header removed) repacked MSB-first into 64-byte flits
  task automatic expect_payload();
    int p, nf;
    p  = frame.size() - 14;
    nf = (p + 63) / 64;
    for (int f = 0; f < nf; f++) begin
      flit_t x;
      x.data  = pack_word(14 + f * 64, frame.size());
      x.sop   = (f == 0);
      x.eop   = (f == nf - 1);
      x.empty = (f == nf - 1) ? 6'(nf * 64 - p) : 6'd0;
      exp_q.push_back(x);
    end
  endtask

  task automatic check_out(input string name, input int n_exp, input int last_empty_exp);
    int t, m;
    t = 0;
    while (got_q.size() < n_exp && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    repeat (6) @(posedge clk);
    #1;
    chk({name, ".n_flits"}, got_q.size(), n_exp);
    chk({name, ".n_model"}, exp_q.size(), n_exp);
    if (got_q.size() > 0 && n_exp > 0)
      chk({name, ".last_empty"}, got_q[got_q.size()-1].empty, last_empty_exp);
    m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < m; i++) begin
      chk($sformatf("%s.f%0d.data", name, i), got_q[i].data, exp_q[i].data);
      chk($sformatf("%s.f%0d.sop", name, i), got_q[i].sop, exp_q[i].sop);
      chk($sformatf("%s.f%0d.eop", name, i), got_q[i].eop, exp_q[i].eop);
      chk($sformatf("%s.f%0d.empty", name, i), got_q[i].empty, exp_q[i].empty);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; in_data = '0; in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_empty = '0;
    out_usr_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.in_ready", in_ready, 0);
    chk("rst.valid", out_usr_valid, 0);
    chk("rst.sop", out_usr_sop, 0);
    chk("rst.eop", out_usr_eop, 0);
    chk("rst.empty", out_usr_empty, 0);
    chk("rst.drop_cnt", drop_cnt, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // 3-flit frame, last empty 10 -> 3 outputs, last empty 24
    build_frame(182, SRC_MAC, ETH_USR, 8'h10);
    expect_payload();
    send_frame(8, 1'b0);
    check_out("three_flit", 3, 24);

    // 2-flit frame, last empty 54 -> 1 output, empty 4
    build_frame(74, SRC_MAC, ETH_USR, 8'h31);
    expect_payload();
    send_frame(8, 1'b0);
    check_out("two_flit", 1, 4);

    // single flit, empty 20 -> {payload,0}, empty 34
    build_frame(44, SRC_MAC, ETH_USR, 8'h52);
    expect_payload();
    send_frame(8, 1'b0);
    check_out("single", 1, 34);

    // non-sop flit while idle is discarded silently
    send_flit({16{32'hDEAD_BEEF}}, 1'b0, 1'b1, 6'd0);
    check_out("no_sop", 0, 0);
    chk("no_sop.drop_cnt", drop_cnt, 0);

    // runt sop flit (empty 60) is dropped and counted
    send_flit({16{32'hCAFE_F00D}}, 1'b1, 1'b1, 6'd60);
    check_out("runt", 0, 0);
    chk("runt.drop_cnt", drop_cnt, 1);
    build_frame(100, SRC_MAC, ETH_USR, 8'h77);
    expect_payload();
    send_frame(8, 1'b0);
    check_out("after_runt", 2, 42);

    // 4-flit frame with back-pressure toggling every cycle, ending in TAIL
    toggle_en = 1'b1;
    build_frame(236, SRC_MAC, ETH_USR, 8'h9C);
    expect_payload();
    send_frame(8, 1'b1);
    check_out("toggle", 4, 34);
    toggle_en = 1'b0;
    out_usr_ready = 1'b1;

    // frame carrying IPv4 ethertype
    build_frame(150, DST_MAC, 16'h0800, 8'hA5);
`ifdef USR_STRIP_ETYPE_CHECK_EN
    send_frame(8, 1'b0);
    check_out("etype_bad", 0, 0);
    chk("etype_bad.drop_cnt", drop_cnt, 2);
`else
    expect_payload();
    send_frame(8, 1'b0);
    check_out("etype_pass", 3, 56);
    chk("etype_pass.drop_cnt", drop_cnt, 1);
`endif
    build_frame(130, SRC_MAC, ETH_USR, 8'h3E);
    expect_payload();
    send_frame(8, 1'b0);
    check_out("etype_good", 2, 12);

    // reset in the middle of a frame abandons it
    build_frame(182, SRC_MAC, ETH_USR, 8'h44);
    send_frame(1, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst.in_ready", in_ready, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("midrst.drop_cnt", drop_cnt, 0);
    chk("midrst.valid", out_usr_valid, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    build_frame(74, SRC_MAC, ETH_USR, 8'h61);
    expect_payload();
    send_frame(8, 1'b0);
    check_out("after_rst", 1, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
